// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding select, load-use / memory-wait stall and redirect flush control
module hazard_forward_unit #(
  parameter int  NUM_FWD      = 2,
  parameter int  FLUSH_CYCLES = 1,
  parameter int  CNT_W        = 16,
  localparam int SEL_W        = $clog2(NUM_FWD + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           inst_id_i,
  input  logic [31:0]           inst_ex_i,
  input  logic                  valid_ex_i,
  input  logic [32*NUM_FWD-1:0] fwd_inst_i,
  input  logic [NUM_FWD-1:0]    fwd_regwen_i,
  input  logic                  load_mem_i,
  input  logic                  dmem_ready_i,
  input  logic                  check_jump_i,
  output logic [SEL_W-1:0]      Asel_o,
  output logic [SEL_W-1:0]      Bsel_o,
  output logic                  stall_o,
  output logic                  bubble_ex_o,
  output logic                  flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
  endfunction

  logic [4:0] ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2;
  logic       ex_reads_rs1, ex_reads_rs2;

  assign ex_rs1       = inst_ex_i[19:15];
  assign ex_rs2       = inst_ex_i[24:20];
  assign ex_rd        = inst_ex_i[11:7];
  assign id_rs1       = inst_id_i[19:15];
  assign id_rs2       = inst_id_i[24:20];
  assign ex_reads_rs1 = reads_rs1(inst_ex_i[6:0]);
  assign ex_reads_rs2 = reads_rs2(inst_ex_i[6:0]);

  logic [NUM_FWD-1:0] hit_a, hit_b, unused_fwd;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    logic [4:0] rd;
    assign rd            = fwd_inst_i[32*k+7 +: 5];
    assign hit_a[k]      = fwd_regwen_i[k] && (rd != 5'd0) && (rd == ex_rs1) && ex_reads_rs1;
    assign hit_b[k]      = fwd_regwen_i[k] && (rd != 5'd0) && (rd == ex_rs2) && ex_reads_rs2;
    assign unused_fwd[k] = ^{fwd_inst_i[32*k+12 +: 20], fwd_inst_i[32*k +: 7]};
  end

  logic unused_inst;
  assign unused_inst = ^{inst_ex_i[31:25], inst_ex_i[14:12], inst_id_i[31:25], inst_id_i[14:7]};

  // Scan oldest to youngest so the youngest matching stage overrides.
  logic [SEL_W-1:0] asel_c, bsel_c;
  always_comb begin
    asel_c = '0;
    bsel_c = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit_a[k]) asel_c = SEL_W'(k + 1);
      if (hit_b[k]) bsel_c = SEL_W'(k + 1);
    end
  end

  logic load_use, mem_wait;
  assign load_use = valid_ex_i && (inst_ex_i[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                    ((reads_rs1(inst_id_i[6:0]) && (id_rs1 == ex_rd)) ||
                     (reads_rs2(inst_id_i[6:0]) && (id_rs2 == ex_rd)));
  assign mem_wait = load_mem_i && !dmem_ready_i;

  state_t state_q, state_d;
  logic   stall_c, bubble_c, flush_c;

  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          stall_c = 1'b1;
          state_d = MEM_WAIT;
        end else if (check_jump_i) begin
          flush_c = 1'b1;
          state_d = (FLUSH_CYCLES == 2) ? FLUSH : RUN;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      // Pipeline is frozen here; a pending jump stays held and is taken after the wait.
      MEM_WAIT: begin
        if (dmem_ready_i) state_d = RUN;
        else              stall_c = 1'b1;
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (mem_wait) begin
          stall_c = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Combinational outputs are forced low while reset is held, without waiting for a clock.
  assign Asel_o      = rst_ni ? asel_c : '0;
  assign Bsel_o      = rst_ni ? bsel_c : '0;
  assign stall_o     = rst_ni && stall_c;
  assign bubble_ex_o = rst_ni && bubble_c;
  assign flush_o     = rst_ni && flush_c;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit
module tb_hazard_forward_unit;

  localparam int F_ASEL = 0, F_BSEL = 1, F_STALL = 2, F_BUBBLE = 3, F_FLUSH = 4, F_SCNT = 5, F_FCNT = 6;

  typedef struct {
    string name;
    int    dut;
    int    field;
    int    value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_id, inst_ex;
  logic        valid_ex;
  logic [63:0] fwd_inst;
  logic [1:0]  fwd_regwen;
  logic        load_mem, dmem_ready, check_jump;

  logic [1:0]  asel [3];
  logic [1:0]  bsel [3];
  logic        stall [3];
  logic        bubble [3];
  logic        flush [3];
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
  logic [3:0]  scnt2, fcnt2;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   got;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NUM_FWD(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .inst_id_i(inst_id), .inst_ex_i(inst_ex), .valid_ex_i(valid_ex),
    .fwd_inst_i(fwd_inst), .fwd_regwen_i(fwd_regwen), .load_mem_i(load_mem), .dmem_ready_i(dmem_ready),
    .check_jump_i(check_jump), .Asel_o(asel[0]), .Bsel_o(bsel[0]), .stall_o(stall[0]),
    .bubble_ex_o(bubble[0]), .flush_o(flush[0]), .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

  hazard_forward_unit #(.NUM_FWD(2), .FLUSH_CYCLES(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .inst_id_i(inst_id), .inst_ex_i(inst_ex), .valid_ex_i(valid_ex),
    .fwd_inst_i(fwd_inst), .fwd_regwen_i(fwd_regwen), .load_mem_i(load_mem), .dmem_ready_i(dmem_ready),
    .check_jump_i(check_jump), .Asel_o(asel[1]), .Bsel_o(bsel[1]), .stall_o(stall[1]),
    .bubble_ex_o(bubble[1]), .flush_o(flush[1]), .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

  hazard_forward_unit #(.NUM_FWD(2), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .inst_id_i(inst_id), .inst_ex_i(inst_ex), .valid_ex_i(valid_ex),
    .fwd_inst_i(fwd_inst), .fwd_regwen_i(fwd_regwen), .load_mem_i(load_mem), .dmem_ready_i(dmem_ready),
    .check_jump_i(check_jump), .Asel_o(asel[2]), .Bsel_o(bsel[2]), .stall_o(stall[2]),
    .bubble_ex_o(bubble[2]), .flush_o(flush[2]), .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2));

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd);
    return itype(7'b0010011, 3'b000, rd, 5'd0, 12'd1);
  endfunction

  function automatic int actual(input int d, input int f);
    int sc, fc;
    sc = (d == 0) ? int'(scnt0) : (d == 1) ? int'(scnt1) : int'(scnt2);
    fc = (d == 0) ? int'(fcnt0) : (d == 1) ? int'(fcnt1) : int'(fcnt2);
    case (f)
      F_ASEL:   return int'(asel[d]);
      F_BSEL:   return int'(bsel[d]);
      F_STALL:  return int'(stall[d]);
      F_BUBBLE: return int'(bubble[d]);
      F_FLUSH:  return int'(flush[d]);
      F_SCNT:   return sc;
      default:  return fc;
    endcase
  endfunction

  task automatic expect_v(input string name, input int d, input int f, input int v);
    sb_q.push_back('{name, d, f, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_id    = 32'h0000_0013;
    inst_ex    = 32'h0000_0013;
    valid_ex   = 1'b0;
    fwd_inst   = '0;
    fwd_regwen = 2'b00;
    load_mem   = 1'b0;
    dmem_ready = 1'b0;
    check_jump = 1'b0;
  endtask

  task automatic all_zero(input string tag, input int d);
    expect_v({tag, "_asel"}, d, F_ASEL, 0);
    expect_v({tag, "_bsel"}, d, F_BSEL, 0);
    expect_v({tag, "_stall"}, d, F_STALL, 0);
    expect_v({tag, "_bubble"}, d, F_BUBBLE, 0);
    expect_v({tag, "_flush"}, d, F_FLUSH, 0);
    expect_v({tag, "_scnt"}, d, F_SCNT, 0);
    expect_v({tag, "_fcnt"}, d, F_FCNT, 0);
  endtask

  // Monitor: every negedge, compare everything the stimulus queued for this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      got = actual(e.dut, e.field);
      if (got != e.value) begin
        errors++;
        $display("FAIL %s: dut%0d got %0d expected %0d", e.name, e.dut, got, e.value);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    fwd_inst   = {addi(5'd5), addi(5'd5)};
    fwd_regwen = 2'b11;
    inst_ex    = rtype(7'd0, 5'd6, 5'd5, 5'd5);
    load_mem   = 1'b1;
    check_jump = 1'b1;

    step();
    all_zero("reset", 0);

    step();
    rst_n = 1'b1;
    load_mem = 1'b0;
    check_jump = 1'b0;
    expect_v("youngest_a", 0, F_ASEL, 1);
    expect_v("youngest_b", 0, F_BSEL, 1);
    expect_v("fwd_no_stall", 0, F_STALL, 0);

    step();
    fwd_regwen = 2'b10;
    expect_v("stage2_a", 0, F_ASEL, 2);
    expect_v("stage2_b", 0, F_BSEL, 2);

    step();
    fwd_regwen = 2'b11;
    fwd_inst   = {addi(5'd7), addi(5'd5)};
    inst_ex    = rtype(7'd0, 5'd6, 5'd5, 5'd7);
    expect_v("split_a", 0, F_ASEL, 1);
    expect_v("split_b", 0, F_BSEL, 2);

    step();
    fwd_inst = {addi(5'd3), addi(5'd0)};
    inst_ex  = itype(7'b0010011, 3'b000, 5'd1, 5'd0, 12'd3);
    expect_v("x0_a", 0, F_ASEL, 0);
    expect_v("itype_no_rs2", 0, F_BSEL, 0);

    step();
    fwd_inst = {addi(5'd0), addi(5'd5)};
    inst_ex  = {12'h000, 5'd5, 3'b000, 5'd5, 7'b0110111};
    expect_v("lui_a", 0, F_ASEL, 0);

    step();
    fwd_inst = {addi(5'd2), addi(5'd5)};
    inst_ex  = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011};
    expect_v("store_a", 0, F_ASEL, 2);
    expect_v("store_b", 0, F_BSEL, 1);

    step();
    fwd_inst   = {addi(5'd0), addi(5'd5)};
    fwd_regwen = 2'b01;
    inst_ex    = itype(7'b1100111, 3'b000, 5'd1, 5'd5, 12'd0);
    check_jump = 1'b1;
    expect_v("jalr_a", 0, F_ASEL, 1);
    expect_v("jump_flush", 0, F_FLUSH, 1);
    expect_v("jump_no_stall", 0, F_STALL, 0);
    expect_v("jump_flush_d1", 1, F_FLUSH, 1);

    step();
    idle();
    expect_v("flush1_done", 0, F_FLUSH, 0);
    expect_v("flush1_cnt", 0, F_FCNT, 1);
    expect_v("flush2_second", 1, F_FLUSH, 1);

    step();
    expect_v("flush2_done", 1, F_FLUSH, 0);
    expect_v("flush2_cnt", 1, F_FCNT, 2);

    step();
    inst_ex  = itype(7'b0000011, 3'b010, 5'd7, 5'd2, 12'd0);
    inst_id  = rtype(7'b0100000, 5'd8, 5'd7, 5'd1);
    valid_ex = 1'b1;
    expect_v("loaduse_stall", 0, F_STALL, 1);
    expect_v("loaduse_bubble", 0, F_BUBBLE, 1);
    expect_v("loaduse_flush", 0, F_FLUSH, 0);

    step();
    valid_ex = 1'b0;
    expect_v("bubble_stall", 0, F_STALL, 0);
    expect_v("bubble_bubble", 0, F_BUBBLE, 0);
    expect_v("loaduse_cnt", 0, F_SCNT, 1);

    step();
    valid_ex = 1'b1;
    inst_id  = rtype(7'd0, 5'd8, 5'd1, 5'd7);
    expect_v("loaduse_rs2", 0, F_STALL, 1);

    step();
    inst_ex = itype(7'b0000011, 3'b010, 5'd0, 5'd2, 12'd0);
    inst_id = rtype(7'd0, 5'd8, 5'd0, 5'd1);
    expect_v("load_x0", 0, F_STALL, 0);
    expect_v("load_x0_cnt", 0, F_SCNT, 2);

    step();
    idle();
    load_mem   = 1'b1;
    check_jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v("memwait_stall", 0, F_STALL, 1);
      expect_v("memwait_noflush", 0, F_FLUSH, 0);
      step();
    end
    dmem_ready = 1'b1;
    expect_v("ready_stall", 0, F_STALL, 0);
    expect_v("ready_flush", 0, F_FLUSH, 0);

    step();
    load_mem   = 1'b0;
    dmem_ready = 1'b0;
    expect_v("held_jump_flush", 0, F_FLUSH, 1);
    expect_v("held_jump_stall", 0, F_STALL, 0);
    expect_v("memwait_cnt", 0, F_SCNT, 5);

    step();
    check_jump = 1'b0;
    load_mem   = 1'b1;
    expect_v("run_load_stall", 0, F_STALL, 1);
    expect_v("run_load_flush", 0, F_FLUSH, 0);
    expect_v("flush_cnt_2", 0, F_FCNT, 2);
    expect_v("flushst_load_stall", 1, F_STALL, 1);
    expect_v("flushst_load_flush", 1, F_FLUSH, 1);

    step();
    expect_v("flushst_to_wait_stall", 1, F_STALL, 1);
    expect_v("flushst_to_wait_flush", 1, F_FLUSH, 0);
    expect_v("flushst_fcnt", 1, F_FCNT, 4);

    step();
    dmem_ready = 1'b1;
    expect_v("ready2_stall", 1, F_STALL, 0);
    expect_v("cnt4_before_sat", 2, F_SCNT, 7);

    step();
    dmem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    expect_v("sat_cnt", 2, F_SCNT, 15);
    expect_v("nosat_cnt16", 0, F_SCNT, 27);
    expect_v("still_waiting", 2, F_STALL, 1);

    step();
    rst_n      = 1'b0;
    fwd_inst   = {addi(5'd5), addi(5'd5)};
    fwd_regwen = 2'b11;
    inst_ex    = rtype(7'd0, 5'd6, 5'd5, 5'd5);
    check_jump = 1'b1;
    all_zero("midwait_reset", 0);
    expect_v("midwait_reset_stall4", 2, F_STALL, 0);
    expect_v("midwait_reset_cnt4", 2, F_SCNT, 0);

    step();
    rst_n = 1'b1;
    idle();
    expect_v("post_reset_stall", 0, F_STALL, 0);
    expect_v("post_reset_stall4", 2, F_STALL, 0);

    step();
    check_jump = 1'b1;
    expect_v("post_reset_run_flush", 0, F_FLUSH, 1);
    expect_v("post_reset_scnt", 0, F_SCNT, 0);

    step();
    idle();
    expect_v("post_reset_fcnt", 0, F_FCNT, 1);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
